dmaw_burst_split: RTL and testbench



---
 rtl/dmaw_pkg.sv | 23 ++
 rtl/dmaw_len_fifo.sv | 69 ++++++
 rtl/dmaw_burst_split.sv | 202 ++++++++++++++++++++
 tb/tb_dmaw_burst_split.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/dmaw_pkg.sv
// dmaw_pkg: shared types and constants for the DMA-write burst splitter.
//   state_t      - job FSM state (IDLE / BUSY)
//   BOUNDARY_4K  - AXI burst boundary in bytes
//   blen_width() - width needed to hold a burst length 0..max_bl
//   blen_t       - burst-length type for the default MAX_BL of 16
package dmaw_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } state_t;

  localparam int BOUNDARY_4K    = 4096;
  localparam int MAX_BL_DEFAULT = 16;

  // Bits needed to represent a burst length in the range 0..max_bl.
  function automatic int blen_width(input int max_bl);
    return $clog2(max_bl + 1);
  endfunction

  typedef logic [$clog2(MAX_BL_DEFAULT + 1)-1:0] blen_t;

endpackage

// File: rtl/dmaw_len_fifo.sv
// dmaw_len_fifo: synchronous FIFO of issued burst lengths, used to place WLAST.
// Ports:
//   clk, rst      - clock, synchronous active-high reset
//   push, din     - write one burst length
//   pop           - retire the head entry
//   dout          - head entry (valid when !empty)
//   full, empty   - occupancy flags
// A push while full is accepted only when a pop happens in the same cycle.
module dmaw_len_fifo
  import dmaw_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int WIDTH = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [PW-1:0]    wr_ptr_r;
  logic [PW-1:0]    rd_ptr_r;
  logic [CW-1:0]    cnt_r;
  logic             do_push_s;
  logic             do_pop_s;

  assign full      = (cnt_r == CW'(DEPTH));
  assign empty     = (cnt_r == {CW{1'b0}});
  assign do_pop_s  = pop && !empty;
  assign do_push_s = push && (!full || do_pop_s);
  assign dout      = mem_r[rd_ptr_r];

  // Storage array; contents need no reset because cnt_r qualifies them.
  always_ff @(posedge clk) begin
    if (do_push_s) begin
      mem_r[wr_ptr_r] <= din;
    end else begin
      mem_r[wr_ptr_r] <= mem_r[wr_ptr_r];
    end
  end

  // Pointers and occupancy count.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_r <= {PW{1'b0}};
      rd_ptr_r <= {PW{1'b0}};
      cnt_r    <= {CW{1'b0}};
    end else begin
      if (do_push_s) wr_ptr_r <= wr_ptr_r + PW'(1);
      else           wr_ptr_r <= wr_ptr_r;
      if (do_pop_s)  rd_ptr_r <= rd_ptr_r + PW'(1);
      else           rd_ptr_r <= rd_ptr_r;
      case ({do_push_s, do_pop_s})
        2'b10:   cnt_r <= cnt_r + CW'(1);
        2'b01:   cnt_r <= cnt_r - CW'(1);
        default: cnt_r <= cnt_r;
      endcase
    end
  end

endmodule

// File: rtl/dmaw_burst_split.sv
// dmaw_burst_split: splits one DMA write job (start address, byte length) into
// AXI INCR bursts of at most MAX_BL beats that never cross a 4 KB boundary,
// places WLAST from a queue of issued burst lengths and limits outstanding
// bursts to OD.
// Ports:
//   usr_clk, usr_reset          - clock, synchronous active-high reset
//   cfg_dmaw_*                  - job request (sa, len in bytes; low L bits ignored)
//   dmaw_done, dmaw_err         - job-complete pulse, sticky BRESP error
//   usr_aw*, usr_w*, usr_b*     - AXI master user AW/W/B channels
//   dmaw_data/strb/valid/ready  - write data source (passed straight to W)
// Build option DMAW_BRESP_TRACK_EN: when defined, bursts retire on B responses
// and dmaw_err collects BRESP[1]; otherwise they retire on the WLAST beat and
// dmaw_err is held at 0.
module dmaw_burst_split
  import dmaw_pkg::*;
#(
  parameter int AXI_DW = 128,
  parameter int AXI_AW = 32,
  parameter int AXI_IW = 8,
  parameter int AXI_LW = 8,
  parameter int MAX_BL = 16,
  parameter int OD     = 4,
  parameter int AXI_ID = 1
) (
  input  logic                usr_clk,
  input  logic                usr_reset,
  input  logic                cfg_dmaw_valid,
  output logic                cfg_dmaw_ready,
  input  logic [31:0]         cfg_dmaw_sa,
  input  logic [31:0]         cfg_dmaw_len,
  output logic                dmaw_done,
  output logic                dmaw_err,
  output logic [AXI_IW-1:0]   usr_awid,
  output logic [AXI_AW-1:0]   usr_awaddr,
  output logic [AXI_LW-1:0]   usr_awlen,
  output logic [2:0]          usr_awsize,
  output logic [1:0]          usr_awburst,
  output logic                usr_awvalid,
  input  logic                usr_awready,
  output logic [AXI_DW-1:0]   usr_wdata,
  output logic [AXI_DW/8-1:0] usr_wstrb,
  output logic                usr_wlast,
  output logic                usr_wvalid,
  input  logic                usr_wready,
  input  logic [AXI_IW-1:0]   usr_bid,
  input  logic [1:0]          usr_bresp,
  input  logic                usr_bvalid,
  output logic                usr_bready,
  input  logic [AXI_DW-1:0]   dmaw_data,
  input  logic [AXI_DW/8-1:0] dmaw_strb,
  input  logic                dmaw_valid,
  output logic                dmaw_ready
);

  localparam int L   = $clog2(AXI_DW / 8);
  localparam int ADW = AXI_AW - L;      // beat-address width
  localparam int RW  = 32 - L;          // remaining-beats width
  localparam int PGW = 12 - L;          // beat offset within a 4 KB page
  localparam int BLW = blen_width(MAX_BL);
  localparam int OCW = $clog2(OD + 1);

  state_t         state_r;
  logic [ADW-1:0] addr_r;
  logic [RW-1:0]  rem_r;
  logic [OCW-1:0] out_cnt_r;
  logic [BLW-1:0] bc_r;
  logic           zero_done_r;

  logic [31:0]    to4k_s;
  logic [31:0]    rem_ext_s;
  logic [31:0]    min_bl_s;
  logic [31:0]    burst_w_s;
  logic [BLW-1:0] burst_s;
  logic [BLW-1:0] head_s;
  logic           fifo_full_s;
  logic           fifo_empty_s;
  logic           accept_s;
  logic           aw_hs_s;
  logic           w_hs_s;
  logic           wlast_s;
  logic           retire_s;
  logic           complete_s;
  logic           unused_s;

  // Burst length = min(remaining beats, MAX_BL, beats left in the 4 KB page).
  assign to4k_s    = 32'(BOUNDARY_4K >> L) - 32'(addr_r[PGW-1:0]);
  assign rem_ext_s = 32'(rem_r);
  assign min_bl_s  = (rem_ext_s < 32'(MAX_BL)) ? rem_ext_s : 32'(MAX_BL);
  assign burst_w_s = (to4k_s < min_bl_s) ? to4k_s : min_bl_s;
  assign burst_s   = BLW'(burst_w_s);

  assign cfg_dmaw_ready = (state_r == ST_IDLE);
  assign accept_s       = cfg_dmaw_ready && cfg_dmaw_valid;

  assign usr_awid    = AXI_IW'(AXI_ID);
  assign usr_awaddr  = {addr_r, {L{1'b0}}};
  assign usr_awsize  = 3'(L);
  assign usr_awburst = 2'b01;
  // Guarded so AWLEN reads 0 rather than all-ones when no beats remain.
  assign usr_awlen   = (burst_s == {BLW{1'b0}}) ? {AXI_LW{1'b0}}
                                                : AXI_LW'(burst_s - BLW'(1));
  assign usr_awvalid = (state_r == ST_BUSY) && (rem_r != {RW{1'b0}}) &&
                       (out_cnt_r < OCW'(OD)) && !fifo_full_s;
  assign aw_hs_s     = usr_awvalid && usr_awready;

  // W is a pass-through, held off until its burst has been issued on AW.
  assign usr_wdata  = dmaw_data;
  assign usr_wstrb  = dmaw_strb;
  assign usr_wvalid = dmaw_valid && !fifo_empty_s;
  assign dmaw_ready = usr_wready && !fifo_empty_s;
  assign w_hs_s     = dmaw_valid && usr_wready && !fifo_empty_s;
  assign wlast_s    = !fifo_empty_s && (bc_r == (head_s - BLW'(1)));
  assign usr_wlast  = wlast_s;

  assign usr_bready = 1'b1;

`ifdef DMAW_BRESP_TRACK_EN
  logic err_r;
  assign retire_s = usr_bvalid && (out_cnt_r != {OCW{1'b0}});
  assign dmaw_err = err_r;

  // Sticky BRESP error, cleared when a new job is accepted.
  always_ff @(posedge usr_clk) begin
    if (usr_reset) begin
      err_r <= 1'b0;
    end else if (accept_s) begin
      err_r <= 1'b0;
    end else if (usr_bvalid && usr_bresp[1]) begin
      err_r <= 1'b1;
    end else begin
      err_r <= err_r;
    end
  end
`else
  assign retire_s = w_hs_s && wlast_s;
  assign dmaw_err = 1'b0;
`endif

  assign complete_s = (state_r == ST_BUSY) && (rem_r == {RW{1'b0}}) &&
                      fifo_empty_s && (out_cnt_r == {OCW{1'b0}});
  assign dmaw_done  = zero_done_r || complete_s;

  // Inputs only partly consumed (ignored low/high bits, unchecked BID).
  assign unused_s = ^{cfg_dmaw_sa, cfg_dmaw_len, usr_bid, usr_bresp, usr_bvalid};

  dmaw_len_fifo #(
    .DEPTH (OD),
    .WIDTH (BLW)
  ) u_len_fifo (
    .clk   (usr_clk),
    .rst   (usr_reset),
    .push  (aw_hs_s),
    .din   (burst_s),
    .pop   (w_hs_s && wlast_s),
    .dout  (head_s),
    .full  (fifo_full_s),
    .empty (fifo_empty_s)
  );

  // Job FSM, address/remaining bookkeeping, outstanding count and beat counter.
  always_ff @(posedge usr_clk) begin
    if (usr_reset) begin
      state_r     <= ST_IDLE;
      addr_r      <= {ADW{1'b0}};
      rem_r       <= {RW{1'b0}};
      out_cnt_r   <= {OCW{1'b0}};
      bc_r        <= {BLW{1'b0}};
      zero_done_r <= 1'b0;
    end else begin
      zero_done_r <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (cfg_dmaw_valid) begin
            addr_r <= cfg_dmaw_sa[AXI_AW-1:L];
            rem_r  <= cfg_dmaw_len[31:L];
            // A job shorter than one beat completes without any traffic.
            if (cfg_dmaw_len[31:L] == {RW{1'b0}}) zero_done_r <= 1'b1;
            else                                  state_r     <= ST_BUSY;
          end
        end
        ST_BUSY: begin
          if (aw_hs_s) begin
            addr_r <= addr_r + ADW'(burst_s);
            rem_r  <= rem_r - RW'(burst_s);
          end
          if (complete_s) state_r <= ST_IDLE;
        end
        default: state_r <= ST_IDLE;
      endcase

      case ({aw_hs_s, retire_s})
        2'b10:   out_cnt_r <= out_cnt_r + OCW'(1);
        2'b01:   out_cnt_r <= out_cnt_r - OCW'(1);
        default: out_cnt_r <= out_cnt_r;
      endcase

      if (w_hs_s) bc_r <= wlast_s ? {BLW{1'b0}} : bc_r + BLW'(1);
      else        bc_r <= bc_r;
    end
  end

endmodule

// File: tb/tb_dmaw_burst_split.sv
module tb_dmaw_burst_split;

  localparam logic [127:0] DATA_PAT = 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210;
`ifdef DMAW_BRESP_TRACK_EN
  localparam logic EXP_ERR = 1'b1;
`else
  localparam logic EXP_ERR = 1'b0;
`endif

  logic         usr_clk = 1'b0;
  logic         usr_reset;
  logic         cfg_dmaw_valid;
  logic         cfg_dmaw_ready;
  logic [31:0]  cfg_dmaw_sa;
  logic [31:0]  cfg_dmaw_len;
  logic         dmaw_done;
  logic         dmaw_err;
  logic [7:0]   usr_awid;
  logic [31:0]  usr_awaddr;
  logic [7:0]   usr_awlen;
  logic [2:0]   usr_awsize;
  logic [1:0]   usr_awburst;
  logic         usr_awvalid;
  logic         usr_awready;
  logic [127:0] usr_wdata;
  logic [15:0]  usr_wstrb;
  logic         usr_wlast;
  logic         usr_wvalid;
  logic         usr_wready;
  logic [7:0]   usr_bid;
  logic [1:0]   usr_bresp;
  logic         usr_bvalid;
  logic         usr_bready;
  logic [127:0] dmaw_data;
  logic [15:0]  dmaw_strb;
  logic         dmaw_valid;
  logic         dmaw_ready;

  always #5 usr_clk = ~usr_clk;

  dmaw_burst_split dut (
    .usr_clk(usr_clk), .usr_reset(usr_reset),
    .cfg_dmaw_valid(cfg_dmaw_valid), .cfg_dmaw_ready(cfg_dmaw_ready),
    .cfg_dmaw_sa(cfg_dmaw_sa), .cfg_dmaw_len(cfg_dmaw_len),
    .dmaw_done(dmaw_done), .dmaw_err(dmaw_err),
    .usr_awid(usr_awid), .usr_awaddr(usr_awaddr), .usr_awlen(usr_awlen),
    .usr_awsize(usr_awsize), .usr_awburst(usr_awburst),
    .usr_awvalid(usr_awvalid), .usr_awready(usr_awready),
    .usr_wdata(usr_wdata), .usr_wstrb(usr_wstrb), .usr_wlast(usr_wlast),
    .usr_wvalid(usr_wvalid), .usr_wready(usr_wready),
    .usr_bid(usr_bid), .usr_bresp(usr_bresp),
    .usr_bvalid(usr_bvalid), .usr_bready(usr_bready),
    .dmaw_data(dmaw_data), .dmaw_strb(dmaw_strb),
    .dmaw_valid(dmaw_valid), .dmaw_ready(dmaw_ready)
  );

  int n_cmp = 0;
  int n_bad = 0;
  int cycle = 0;
  int aw_cnt, w_beats, wl_cnt, b_cnt, pending_b, done_cnt;
  int done_cyc, wl_cyc, first_b_cyc, last_b_cyc, acc_cyc, err_idx;
  bit b_hold;
  logic done_err;
  logic [31:0] aw_addr [16];
  logic [7:0]  aw_len  [16];
  int          aw_cyc  [16];
  int          wl_beat [16];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic clear_log();
    aw_cnt = 0; w_beats = 0; wl_cnt = 0; b_cnt = 0; done_cnt = 0;
    done_cyc = -1; wl_cyc = -1; first_b_cyc = -1; last_b_cyc = -1;
    done_err = 1'bx;
  endtask

  // One clock: log the handshakes of this cycle, advance, then drive B.
  task automatic cyc();
    #1;
    if (usr_awvalid && usr_awready) begin
      if (aw_cnt < 16) begin
        aw_addr[aw_cnt] = usr_awaddr;
        aw_len[aw_cnt]  = usr_awlen;
        aw_cyc[aw_cnt]  = cycle;
      end
      aw_cnt++;
    end
    if (usr_wvalid && usr_wready) begin
      w_beats++;
      if (usr_wlast) begin
        if (wl_cnt < 16) wl_beat[wl_cnt] = w_beats;
        wl_cyc = cycle;
        wl_cnt++;
        pending_b++;
      end
    end
    if (usr_bvalid && usr_bready) begin
      if (b_cnt == 0) first_b_cyc = cycle;
      last_b_cyc = cycle;
      b_cnt++;
      pending_b--;
    end
    if (dmaw_done) begin
      done_cnt++;
      done_cyc = cycle;
      done_err = dmaw_err;
    end
    @(negedge usr_clk);
    cycle++;
    usr_bvalid = !b_hold && (pending_b > 0);
    usr_bresp  = (b_cnt == err_idx) ? 2'b10 : 2'b00;
  endtask

  task automatic start_job(input logic [31:0] sa, input logic [31:0] len, input string tag);
    cfg_dmaw_sa = sa;
    cfg_dmaw_len = len;
    cfg_dmaw_valid = 1'b1;
    #1;
    check({tag, "_cfg_ready"}, 64'(cfg_dmaw_ready), 64'd1);
    acc_cyc = cycle;
    cyc();
    cfg_dmaw_valid = 1'b0;
  endtask

  task automatic wait_done(input int max_cyc, input string tag);
    int n = 0;
    while (done_cnt == 0 && n < max_cyc) begin
      cyc();
      n++;
    end
    check({tag, "_done"}, 64'(done_cnt), 64'd1);
  endtask

  task automatic check_reset_vals(input string tag);
    #1;
    check({tag, "_cfg_ready"}, 64'(cfg_dmaw_ready), 64'd1);
    check({tag, "_awvalid"},   64'(usr_awvalid), 64'd0);
    check({tag, "_awaddr"},    64'(usr_awaddr), 64'd0);
    check({tag, "_awlen"},     64'(usr_awlen), 64'd0);
    check({tag, "_wvalid"},    64'(usr_wvalid), 64'd0);
    check({tag, "_wlast"},     64'(usr_wlast), 64'd0);
    check({tag, "_dmaw_ready"},64'(dmaw_ready), 64'd0);
    check({tag, "_bready"},    64'(usr_bready), 64'd1);
    check({tag, "_done"},      64'(dmaw_done), 64'd0);
    check({tag, "_err"},       64'(dmaw_err), 64'd0);
  endtask

  initial begin
    usr_reset = 1'b1;
    cfg_dmaw_valid = 1'b0; cfg_dmaw_sa = 32'd0; cfg_dmaw_len = 32'd0;
    usr_awready = 1'b1; usr_wready = 1'b1;
    usr_bid = 8'd1; usr_bresp = 2'b00; usr_bvalid = 1'b0;
    dmaw_data = DATA_PAT; dmaw_strb = 16'hFFFF; dmaw_valid = 1'b1;
    b_hold = 1'b0; pending_b = 0; err_idx = 99;
    clear_log();
    repeat (2) @(negedge usr_clk);
    usr_reset = 1'b0;
    check_reset_vals("rst");

    // 1: sa=0, len=256 -> one 16-beat burst
    clear_log();
    start_job(32'h0, 32'd256, "t1");
    cyc();
    #1;
    check("t1_wvalid", 64'(usr_wvalid), 64'd1);
    check("t1_wdata", usr_wdata[63:0], DATA_PAT[63:0]);
    check("t1_awsize", 64'(usr_awsize), 64'd4);
    wait_done(100, "t1");
    check("t1_aw_cnt", 64'(aw_cnt), 64'd1);
    check("t1_awaddr", 64'(aw_addr[0]), 64'h0);
    check("t1_awlen", 64'(aw_len[0]), 64'd15);
    check("t1_aw_lat", 64'(aw_cyc[0]), 64'(acc_cyc + 1));
    check("t1_wl_cnt", 64'(wl_cnt), 64'd1);
    check("t1_wl_beat", 64'(wl_beat[0]), 64'd16);
`ifdef DMAW_BRESP_TRACK_EN
    check("t1_done_lat", 64'(done_cyc), 64'(last_b_cyc + 1));
`else
    check("t1_done_lat", 64'(done_cyc), 64'(wl_cyc + 1));
`endif
    check("t1_err", 64'(done_err), 64'd0);

    // 2: sa=0xFF0, len=64 -> 1 beat up to the 4 KB edge, then 3 beats
    clear_log();
    start_job(32'hFF0, 32'd64, "t2");
    wait_done(100, "t2");
    check("t2_aw_cnt", 64'(aw_cnt), 64'd2);
    check("t2_awaddr0", 64'(aw_addr[0]), 64'hFF0);
    check("t2_awlen0", 64'(aw_len[0]), 64'd0);
    check("t2_awaddr1", 64'(aw_addr[1]), 64'h1000);
    check("t2_awlen1", 64'(aw_len[1]), 64'd2);
    check("t2_wl_beat0", 64'(wl_beat[0]), 64'd1);
    check("t2_wl_beat1", 64'(wl_beat[1]), 64'd4);

    // 3: len=2048 with B withheld -> outstanding limit, 8 bursts total
    clear_log();
    b_hold = 1'b1;
    start_job(32'h0, 32'd2048, "t3");
    repeat (100) cyc();
`ifdef DMAW_BRESP_TRACK_EN
    check("t3_aw_held", 64'(aw_cnt), 64'd4);
`else
    check("t3_aw_held", 64'(aw_cnt), 64'd8);
`endif
    b_hold = 1'b0;
    wait_done(300, "t3");
    check("t3_aw_cnt", 64'(aw_cnt), 64'd8);
`ifdef DMAW_BRESP_TRACK_EN
    check("t3_aw5_lat", 64'(aw_cyc[4]), 64'(first_b_cyc + 1));
`endif
    for (int i = 0; i < 8; i++) begin
      check($sformatf("t3_awaddr%0d", i), 64'(aw_addr[i]), 64'(i * 256));
      check($sformatf("t3_awlen%0d", i), 64'(aw_len[i]), 64'd15);
    end
    check("t3_wl_beat7", 64'(wl_beat[7]), 64'd128);

    // 4: len=1024 with an error response on the 2nd burst, then a clean job
    clear_log();
    err_idx = 1;
    start_job(32'h0, 32'd1024, "t4a");
    wait_done(200, "t4a");
    check("t4a_err", 64'(done_err), 64'(EXP_ERR));
    err_idx = 99;
    clear_log();
    start_job(32'h2000, 32'd256, "t4b");
    #1;
    check("t4b_err_cleared", 64'(dmaw_err), 64'd0);
    wait_done(100, "t4b");
    check("t4b_err", 64'(done_err), 64'd0);

    // 5: len=8 is shorter than a beat -> no traffic, done next cycle
    clear_log();
    start_job(32'h100, 32'd8, "t5");
    wait_done(5, "t5");
    check("t5_done_lat", 64'(done_cyc), 64'(acc_cyc + 1));
    check("t5_aw_cnt", 64'(aw_cnt), 64'd0);
    check("t5_w_beats", 64'(w_beats), 64'd0);

    // 6: reset after two AW handshakes, then a new job with AW back-pressure
    clear_log();
    b_hold = 1'b1;
    start_job(32'h0, 32'd2048, "t6");
    for (int n = 0; n < 20 && aw_cnt < 2; n++) cyc();
    check("t6_two_aw", 64'(aw_cnt), 64'd2);
    usr_reset = 1'b1;
    cyc();
    usr_reset = 1'b0;
    pending_b = 0;
    usr_bvalid = 1'b0;
    b_hold = 1'b0;
    check_reset_vals("t6_rst");
    clear_log();
    usr_awready = 1'b0;
    start_job(32'h40, 32'd32, "t6n");
    for (int k = 0; k < 2; k++) begin
      #1;
      check($sformatf("t6n_awvalid%0d", k), 64'(usr_awvalid), 64'd1);
      check($sformatf("t6n_awaddr%0d", k), 64'(usr_awaddr), 64'h40);
      check($sformatf("t6n_awlen%0d", k), 64'(usr_awlen), 64'd1);
      cyc();
    end
    usr_awready = 1'b1;
    wait_done(50, "t6n");
    check("t6n_aw_cnt", 64'(aw_cnt), 64'd1);
    check("t6n_awaddr", 64'(aw_addr[0]), 64'h40);
    check("t6n_wl_beat", 64'(wl_beat[0]), 64'd2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
